// File: rtl/pattern_seq_gen.sv
// Multi-channel pattern sequencer: a prescaler tick walks a writable pattern memory
// and drives one registered output bit per channel, in loop or one-shot mode.
module pattern_seq_gen #(
    parameter int                          CLK_DIV    = 12500000,
    parameter int                          PAT_LEN    = 12,
    parameter int                          CHANNELS   = 1,
    parameter logic [PAT_LEN*CHANNELS-1:0] PATTERN    = 12'hCDC,
    parameter bit                          IDLE_LEVEL = 1'b0,
    localparam int                         SW         = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iSTART,
    input  logic                iSTOP,
    input  logic                iEN,
    input  logic                iMODE,
    input  logic                iWE,
    input  logic [SW-1:0]       iADDR,
    input  logic [CHANNELS-1:0] iDATA,
    output logic [CHANNELS-1:0] oSIG,
    output logic [SW-1:0]       oSTEP,
    output logic                oTICK,
    output logic                oBUSY,
    output logic                oDONE
);

    localparam int                  PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]       DIV_MAX  = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0]       STEP_MAX = SW'(PAT_LEN - 1);
    localparam logic [CHANNELS-1:0] IDLE_SIG = {CHANNELS{IDLE_LEVEL}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SW-1:0]       r_step,  w_step_nxt;
    logic [PW-1:0]       r_presc, w_presc_nxt;
    logic                r_mode,  w_mode_nxt;
    logic                w_done_nxt;
    logic                w_tick;
    logic                w_addr_ok;
    logic                r_done;
    logic [CHANNELS-1:0] r_sig;
    logic [CHANNELS-1:0] r_mem [PAT_LEN];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_presc <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_presc <= w_presc_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_presc_nxt = r_presc;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        w_tick      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iSTART && !iSTOP) begin
                    w_state_nxt = S_RUN;
                    w_step_nxt  = '0;
                    w_presc_nxt = '0;
                    w_mode_nxt  = iMODE;
                end
            end
            S_RUN: begin
                if (iSTOP) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                    w_presc_nxt = '0;
                end else if (iSTART) begin
                    // Restart discards any tick falling due in this cycle.
                    w_step_nxt  = '0;
                    w_presc_nxt = '0;
                    w_mode_nxt  = iMODE;
                end else if (iEN) begin
                    if (r_presc == DIV_MAX) begin
                        w_tick      = 1'b1;
                        w_presc_nxt = '0;
                        if (r_step != STEP_MAX) begin
                            w_step_nxt = r_step + SW'(1);
                        end else begin
                            w_step_nxt = '0;
                            if (r_mode) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        oBUSY = (r_state == S_RUN);
        oTICK = w_tick;
    end

    assign w_addr_ok = (32'(iADDR) < PAT_LEN);

    // NOTE: the pattern memory is reset to PATTERN, so it is built from flops, not a RAM macro.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int k = 0; k < PAT_LEN; k++) begin
                r_mem[k] <= PATTERN[k*CHANNELS +: CHANNELS];
            end
            r_sig  <= IDLE_SIG;
            r_done <= 1'b0;
        end else begin
            if (iWE && w_addr_ok) begin
                r_mem[iADDR] <= iDATA;
            end
            r_sig  <= (r_state == S_RUN) ? r_mem[w_step_nxt] : IDLE_SIG;
            r_done <= w_done_nxt;
        end
    end

    assign oSIG  = r_sig;
    assign oSTEP = r_step;
    assign oDONE = r_done;

endmodule
